wide_alu_sequencer: RTL
=======================

# wide_alu_sequencer

- Multi-byte operation sequencer sitting directly upstream of the 8-bit ALU.
- Accepts one wide operation on `NBYTES`-byte operands, then drives the ALU one byte per cycle, chaining carry/shift bits through `SC_in`/`SC_out`.
- Collects the ALU's byte results into a wide result with carry and zero flags, and signals completion with a one-cycle `Done` pulse.

## Interface
Parameters:
- `W`, 8: ALU byte width.
- `NBYTES`, 2: bytes per wide operand; legal range 2..4.

Ports:
- `Clk`, input, 1: the single clock.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: request a new operation; sampled only in IDLE.
- `Op`, input, `wide_op_t`: wide opcode.
- `OpA`, input, `W*NBYTES`: first wide operand.
- `OpB`, input, `W*NBYTES`: second wide operand.
- `AluA`, output, `W`: ALU `InputA`.
- `AluB`, output, `W`: ALU `InputB`.
- `AluOP`, output, `op_mne`: ALU opcode.
- `AluSCin`, output, 1: ALU `SC_in`.
- `AluOut`, input, `W`: ALU `Out`.
- `AluSCout`, input, 1: ALU `SC_out`.
- `AluZero`, input, 1: ALU `Zero`.
- `Busy`, output, 1: high in RUN and DONE.
- `Done`, output, 1: one-cycle completion pulse.
- `Error`, output, 1: high together with `Done` for an illegal `Op`.
- `Result`, output, `W*NBYTES`: wide result; held until the next accepted `Start`.
- `CarryOut`, output, 1: final carry or shifted-out bit.
- `ZeroOut`, output, 1: `Result == 0`.

## Operation
- **States:** IDLE → RUN → DONE → IDLE.
- **Start acceptance:** in IDLE, `Start=1` latches `Op`, `OpA`, `OpB`, clears the carry register and sets the zero accumulator to 1.
  - Legal `Op` → RUN with byte index 0.
  - Illegal `Op` → DONE directly, with `Result=0` and `Error=1`.
- **RUN:** one byte per cycle; the state holds for exactly `NBYTES` cycles.
  - The ALU is driven combinationally from registered state.
  - At each clock edge the sequencer stores `AluOut` into the current result byte, stores `AluSCout` in the carry register, and ANDs `AluZero` into the zero accumulator.
- **Byte order:** RSH/ROR process from the MSB byte down; all other ops from the LSB byte up.
- **Op lowering:**
  - ADD → ALU ADD. `SC_in` is 0 on the first byte, then the previous carry.
  - SUB → ALU ADD with `AluB = ~byte(OpB)`. `SC_in` is 1 on the first byte, then the previous carry. `CarryOut=1` means no borrow.
  - LSH/RSH → ALU LSH/RSH. `SC_in` is 0 on the first byte, then the previous carry. `CarryOut` is the bit shifted out of the wide word.
  - AND/OR/XOR → the same ALU op, with `SC_in=0`. `CarryOut` is forced to 0.
- **DONE:** lasts one cycle with `Done=1`, then returns to IDLE.
  - `Result`, `CarryOut` and `ZeroOut` stay valid from DONE until the next accepted `Start`.
- **Simultaneous and mid-operation events:**
  - `Start` during RUN or DONE is ignored; it is not queued.
  - `Start` in the cycle DONE returns to IDLE is accepted normally.
- **Outputs in IDLE and DONE:** `AluA=0`, `AluB=0`, `AluOP=ADD`, `AluSCin=0`.
- **Reset:** `Reset` low forces IDLE at any time, including mid-RUN. All outputs are 0 (`ZeroOut=1`) while `Reset` is low and after its release. The partial result is discarded.

## Timing
- Latency: `Start` sampled at edge 0 → `Done` high in cycle `NBYTES+1` (3 cycles for `NBYTES=2`).
- Throughput: one operation per `NBYTES+2` cycles.
- No combinational path from `Start`/`Op`/`OpA`/`OpB` to any output.
- The ALU loop (`AluA` → `AluOut`) completes in one cycle.
- Byte index counter: `$clog2(NBYTES)` bits; it never wraps inside RUN.

## Configuration
- **`WIDE_ROTATE_EN` defined:** ROL and ROR are legal.
  - ROL uses the LSB-up order; its first-byte `SC_in` is the latched `OpA` MSB.
  - ROR uses the MSB-down order; its first-byte `SC_in` is the latched `OpA` LSB.
  - `CarryOut` is the rotated-out bit.
- **Not defined:** ROL/ROR are illegal and take the `Error` path.

## Structure
- `wide_op_t` (ADD, SUB, AND, OR, XOR, LSH, RSH, ROL, ROR) is defined in the shared `Definitions` package next to `op_mne`.
- The state enum `wseq_state_t` is also defined in `Definitions`.
- No sub-module: the ALU is instantiated by the parent, beside this block.

## Test plan
All scenarios use `NBYTES=2`.
1. ADD `0x00FF` + `0x0001` → `Result=0x0100`, `CarryOut=0`, `ZeroOut=0`. `Done` pulses exactly 3 cycles after `Start`, for 1 cycle.
2. SUB tests:
   - `0x0100` − `0x0001` → `0x00FF`, `CarryOut=1`.
   - `0x0000` − `0x0001` → `0xFFFF`, `CarryOut=0`.
3. Shift tests:
   - LSH `0x8080` → `0x0100`, `CarryOut=1`.
   - RSH `0x0101` → `0x0080`, `CarryOut=1`.
4. XOR `0xA5A5` ^ `0xA5A5` → `0x0000`, `ZeroOut=1`, `CarryOut=0`.
5. Handshake and reset:
   - `Start` pulsed again during RUN → ignored, exactly one `Done`.
   - `Reset` low in the second RUN cycle → `Busy=0`, `Result=0` immediately, no `Done`.
6. ROL `0x8001`:
   - With `WIDE_ROTATE_EN` → `0x0003`, `CarryOut=1`.
   - Without it → `Done` and `Error` high in cycle 1, `Result=0`.

Source files
------------

// File: rtl/wide_alu_sequencer_pkg.sv
// Shared type definitions for the wide ALU sequencer: the 8-bit ALU opcode
// set, the wide opcode set accepted by the sequencer, and the sequencer
// state encoding.
package wide_alu_sequencer_pkg;

    // Opcodes understood by the 8-bit ALU sitting beside the sequencer.
    typedef enum logic [2:0] {
        ADD = 3'd0,
        AND = 3'd1,
        OR  = 3'd2,
        XOR = 3'd3,
        LSH = 3'd4,
        RSH = 3'd5
    } op_mne;

    // Wide opcodes; encodings outside this list are illegal.
    typedef enum logic [3:0] {
        W_ADD = 4'd0,
        W_SUB = 4'd1,
        W_AND = 4'd2,
        W_OR  = 4'd3,
        W_XOR = 4'd4,
        W_LSH = 4'd5,
        W_RSH = 4'd6,
        W_ROL = 4'd7,
        W_ROR = 4'd8
    } wide_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wseq_state_t;

    // Right-going shifts/rotates must start at the MSB byte so the bit
    // leaving each byte can enter the next lower one.
    function automatic logic msb_first(wide_op_t op);
        return (op == W_RSH) || (op == W_ROR);
    endfunction

endpackage

// File: rtl/wide_alu_sequencer_if.sv
// Bus between the wide ALU sequencer, its requester and the 8-bit ALU.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface wide_alu_sequencer_if #(
    parameter int W      = 8,
    parameter int NBYTES = 2
) ();
    import wide_alu_sequencer_pkg::*;

    logic                  Start;
    wide_op_t              Op;
    logic [W*NBYTES-1:0]   OpA;
    logic [W*NBYTES-1:0]   OpB;
    logic [W-1:0]          AluA;
    logic [W-1:0]          AluB;
    op_mne                 AluOP;
    logic                  AluSCin;
    logic [W-1:0]          AluOut;
    logic                  AluSCout;
    logic                  AluZero;
    logic                  Busy;
    logic                  Done;
    logic                  Error;
    logic [W*NBYTES-1:0]   Result;
    logic                  CarryOut;
    logic                  ZeroOut;

    modport slave (
        input  Start, Op, OpA, OpB, AluOut, AluSCout, AluZero,
        output AluA, AluB, AluOP, AluSCin,
        output Busy, Done, Error, Result, CarryOut, ZeroOut
    );

    modport master (
        output Start, Op, OpA, OpB, AluOut, AluSCout, AluZero,
        input  AluA, AluB, AluOP, AluSCin,
        input  Busy, Done, Error, Result, CarryOut, ZeroOut
    );

endinterface

// File: rtl/wide_alu_sequencer.sv
// Wide ALU sequencer: latches one NBYTES-wide operation, walks the 8-bit ALU
// through it one byte per cycle chaining carry/shift bits, and reports the
// wide result with carry and zero flags on a one-cycle Done pulse.
// Optional feature macro: WIDE_ROTATE_EN makes ROL/ROR legal operations.
module wide_alu_sequencer
    import wide_alu_sequencer_pkg::*;
#(
    parameter int W      = 8,
    parameter int NBYTES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    wide_alu_sequencer_if.slave  bus
);

    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    wseq_state_t            state_q;
    wseq_state_t            state_d;
    logic [IDXW-1:0]        idx_q;
    wide_op_t               op_q;
    logic [W*NBYTES-1:0]    a_q;
    logic [W*NBYTES-1:0]    b_q;
    logic [W*NBYTES-1:0]    res_q;
    logic                   carry_q;
    logic                   zero_q;
    logic                   err_q;

    logic [IDXW-1:0]        pos;
    logic                   first;
    logic                   is_logic_op;
    logic [W-1:0]           a_byte;
    logic [W-1:0]           b_byte;
    logic [W-1:0]           alu_a;
    logic [W-1:0]           alu_b;
    op_mne                  alu_op;
    logic                   alu_scin;

    function automatic logic op_legal(wide_op_t op);
        case (op)
            W_ADD, W_SUB, W_AND, W_OR, W_XOR, W_LSH, W_RSH: return 1'b1;
`ifdef WIDE_ROTATE_EN
            W_ROL, W_ROR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    assign pos         = msb_first(op_q) ? (LAST_IDX - idx_q) : idx_q;
    assign first       = (idx_q == '0);
    assign is_logic_op = (op_q == W_AND) || (op_q == W_OR) || (op_q == W_XOR);
    assign a_byte      = a_q[pos*W +: W];
    assign b_byte      = b_q[pos*W +: W];

    // State register for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus lowering of the current wide-op byte onto the ALU.
    always_comb begin
        state_d  = state_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = ADD;
        alu_scin = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = op_legal(bus.Op) ? RUN : DONE;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
                alu_a = a_byte;
                alu_b = b_byte;
                case (op_q)
                    W_ADD: begin
                        alu_op   = ADD;
                        alu_scin = first ? 1'b0 : carry_q;
                    end
                    W_SUB: begin
                        alu_op   = ADD;
                        alu_b    = ~b_byte;
                        alu_scin = first ? 1'b1 : carry_q;
                    end
                    W_AND: alu_op = AND;
                    W_OR:  alu_op = OR;
                    W_XOR: alu_op = XOR;
                    W_LSH: begin
                        alu_op   = LSH;
                        alu_scin = first ? 1'b0 : carry_q;
                    end
                    W_RSH: begin
                        alu_op   = RSH;
                        alu_scin = first ? 1'b0 : carry_q;
                    end
`ifdef WIDE_ROTATE_EN
                    W_ROL: begin
                        alu_op   = LSH;
                        alu_scin = first ? a_q[W*NBYTES-1] : carry_q;
                    end
                    W_ROR: begin
                        alu_op   = RSH;
                        alu_scin = first ? a_q[0] : carry_q;
                    end
`endif
                    default: ;
                endcase
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on Start and per-byte collection of ALU results.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idx_q   <= '0;
            op_q    <= W_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        idx_q   <= '0;
                        op_q    <= bus.Op;
                        a_q     <= bus.OpA;
                        b_q     <= bus.OpB;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        zero_q  <= 1'b1;
                        err_q   <= !op_legal(bus.Op);
                    end
                end
                RUN: begin
                    res_q[pos*W +: W] <= bus.AluOut;
                    carry_q           <= is_logic_op ? 1'b0 : bus.AluSCout;
                    zero_q            <= zero_q & bus.AluZero;
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.AluA     = alu_a;
    assign bus.AluB     = alu_b;
    assign bus.AluOP    = alu_op;
    assign bus.AluSCin  = alu_scin;
    assign bus.Busy     = (state_q != IDLE);
    assign bus.Done     = (state_q == DONE);
    assign bus.Error    = (state_q == DONE) && err_q;
    assign bus.Result   = res_q;
    assign bus.CarryOut = carry_q;
    assign bus.ZeroOut  = zero_q;

endmodule
